// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bundles the requester-side handshakes and the SRAM pad-side signals of
//   sram_arbiter into one interface.
//   Modports:
//     slave  - used by the arbiter: i_* are inputs, o_* are outputs.
//     master - used by the surrounding logic (requesters + pad wrapper).
//   Signals:
//     i_rd_req/i_rd_addr[19:0]            read request, held until o_rd_gnt
//     o_rd_gnt, o_rd_valid, o_rd_data[15:0]
//     i_wr_req/i_wr_addr[19:0]/i_wr_data[15:0]/i_wr_be[1:0]
//     o_wr_gnt, o_busy
//     o_sram_addr[19:0], o_sram_dq_out[15:0], o_sram_dq_oe, i_sram_dq[15:0]
//     o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
interface sram_arbiter_if;
  logic        i_rd_req;
  logic [19:0] i_rd_addr;
  logic        o_rd_gnt;
  logic        o_rd_valid;
  logic [15:0] o_rd_data;
  logic        i_wr_req;
  logic [19:0] i_wr_addr;
  logic [15:0] i_wr_data;
  logic [1:0]  i_wr_be;
  logic        o_wr_gnt;
  logic        o_busy;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_dq_out;
  logic        o_sram_dq_oe;
  logic [15:0] i_sram_dq;
  logic        o_sram_ce_n;
  logic        o_sram_oe_n;
  logic        o_sram_we_n;
  logic        o_sram_lb_n;
  logic        o_sram_ub_n;

  modport slave (
    input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data, i_wr_be, i_sram_dq,
    output o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt, o_busy,
           o_sram_addr, o_sram_dq_out, o_sram_dq_oe,
           o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
  );

  modport master (
    output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data, i_wr_be, i_sram_dq,
    input  o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt, o_busy,
           o_sram_addr, o_sram_dq_out, o_sram_dq_oe,
           o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Single-port controller for a 1M x 16 asynchronous SRAM shared between a
//   high-priority display read port and a low-priority asset-loader write
//   port. Arbitration happens only in IDLE; all SRAM control pins are
//   registered and sequenced by one FSM:
//     IDLE -> RD (READ_WAIT cycles) -> IDLE
//     IDLE -> WR_SETUP -> WR_PULSE (WRITE_WAIT cycles) -> WR_HOLD -> IDLE
//   Ports:
//     i_clk  system clock
//     i_rst  synchronous active-high reset
//     bus    sram_arbiter_if.slave (requester handshakes + SRAM pad signals)
//   Parameters: READ_WAIT (1..15), WRITE_WAIT (1..15), STARVE_MAX (1..255).
//   Optional feature: define SRAM_ARB_STARVE_GUARD_EN to let a waiting write
//   win after STARVE_MAX consecutive read grants. Without it reads have
//   strict priority and a write may starve.
module sram_arbiter #(
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sram_arbiter_if.slave bus
);

  // Elaboration-time range checks on the configuration.
  if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_bad_read_wait
    $error("sram_arbiter: READ_WAIT out of range 1..15");
  end
  if (WRITE_WAIT < 1 || WRITE_WAIT > 15) begin : g_bad_write_wait
    $error("sram_arbiter: WRITE_WAIT out of range 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("sram_arbiter: STARVE_MAX out of range 1..255");
  end

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  state_t      state_reg;
  logic [3:0]  wait_reg;
  logic [19:0] addr_reg;
  logic [15:0] dq_out_reg;
  logic        dq_oe_reg;
  logic        ce_n_reg, oe_n_reg, we_n_reg, lb_n_reg, ub_n_reg;
  logic [15:0] rd_data_reg;
  logic        rd_valid_reg;

  logic idle;
  logic force_wr;
  logic rd_gnt;
  logic wr_gnt;

  assign idle = (state_reg == IDLE);

`ifdef SRAM_ARB_STARVE_GUARD_EN
  logic [7:0] starve_reg;

  // Counts read grants that overtook a waiting write; the write wins once
  // the count reaches STARVE_MAX.
  assign force_wr = (starve_reg == 8'(STARVE_MAX));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_reg <= 8'd0;
    end else if (wr_gnt) begin
      starve_reg <= 8'd0;
    end else if (rd_gnt && bus.i_wr_req) begin
      starve_reg <= starve_reg + 8'd1;
    end else if (idle && !bus.i_wr_req) begin
      starve_reg <= 8'd0;
    end
  end
`else
  assign force_wr = 1'b0;
`endif

  // Grants are combinational but masked during reset so a request held
  // across reset is only accepted once reset has been released.
  assign rd_gnt = idle && !i_rst && bus.i_rd_req && !(force_wr && bus.i_wr_req);
  assign wr_gnt = idle && !i_rst && bus.i_wr_req && (!bus.i_rd_req || force_wr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      wait_reg     <= 4'd0;
      addr_reg     <= 20'd0;
      dq_out_reg   <= 16'd0;
      dq_oe_reg    <= 1'b0;
      ce_n_reg     <= 1'b1;
      oe_n_reg     <= 1'b1;
      we_n_reg     <= 1'b1;
      lb_n_reg     <= 1'b1;
      ub_n_reg     <= 1'b1;
      rd_data_reg  <= 16'd0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rd_gnt) begin
            state_reg <= RD;
            addr_reg  <= bus.i_rd_addr;
            ce_n_reg  <= 1'b0;
            oe_n_reg  <= 1'b0;
            we_n_reg  <= 1'b1;
            lb_n_reg  <= 1'b0;
            ub_n_reg  <= 1'b0;
            dq_oe_reg <= 1'b0;
            wait_reg  <= 4'(READ_WAIT - 1);
          end else if (wr_gnt) begin
            state_reg  <= WR_SETUP;
            addr_reg   <= bus.i_wr_addr;
            dq_out_reg <= bus.i_wr_data;
            dq_oe_reg  <= 1'b1;
            ce_n_reg   <= 1'b0;
            oe_n_reg   <= 1'b1;
            we_n_reg   <= 1'b1;
            lb_n_reg   <= ~bus.i_wr_be[0];
            ub_n_reg   <= ~bus.i_wr_be[1];
          end
        end
        RD: begin
          // Data is captured on the edge ending the last wait cycle.
          if (wait_reg == 4'd0) begin
            rd_data_reg  <= bus.i_sram_dq;
            rd_valid_reg <= 1'b1;
            state_reg    <= IDLE;
            ce_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            lb_n_reg     <= 1'b1;
            ub_n_reg     <= 1'b1;
          end else begin
            wait_reg <= wait_reg - 4'd1;
          end
        end
        WR_SETUP: begin
          state_reg <= WR_PULSE;
          we_n_reg  <= 1'b0;
          wait_reg  <= 4'(WRITE_WAIT - 1);
        end
        WR_PULSE: begin
          if (wait_reg == 4'd0) begin
            state_reg <= WR_HOLD;
            we_n_reg  <= 1'b1;
          end else begin
            wait_reg <= wait_reg - 4'd1;
          end
        end
        WR_HOLD: begin
          // Data stays driven one cycle past the WE_n rising edge.
          state_reg <= IDLE;
          ce_n_reg  <= 1'b1;
          lb_n_reg  <= 1'b1;
          ub_n_reg  <= 1'b1;
          dq_oe_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_rd_gnt      = rd_gnt;
  assign bus.o_wr_gnt      = wr_gnt;
  assign bus.o_busy        = !idle;
  assign bus.o_rd_valid    = rd_valid_reg;
  assign bus.o_rd_data     = rd_data_reg;
  assign bus.o_sram_addr   = addr_reg;
  assign bus.o_sram_dq_out = dq_out_reg;
  assign bus.o_sram_dq_oe  = dq_oe_reg;
  assign bus.o_sram_ce_n   = ce_n_reg;
  assign bus.o_sram_oe_n   = oe_n_reg;
  assign bus.o_sram_we_n   = we_n_reg;
  assign bus.o_sram_lb_n   = lb_n_reg;
  assign bus.o_sram_ub_n   = ub_n_reg;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Single-port controller for the external 1M x 16 async SRAM (20-bit word address).
- Shares the SRAM between two requesters:
  - the display pixel-fetch read port, which is high priority and fed by the pixel-index-to-word-address encoder;
  - the asset-loader write port, which is low priority.
- Owns every SRAM control pin and sequences multi-cycle read/write timing with an FSM.
- Sits between the display/loader logic and the top-level tristate pad wrapper.

Parameters:
- READ_WAIT, default 1: cycles the SRAM address/OE are held before read data is sampled (1..15).
- WRITE_WAIT, default 2: cycles WE_n is held low in a write (1..15).
- STARVE_MAX, default 8: consecutive read grants allowed while a write waits; used only with SRAM_ARB_STARVE_GUARD_EN (1..255).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_rd_req  in  1  read request; held with i_rd_addr stable until o_rd_gnt
- i_rd_addr  in  20  read word address
- o_rd_gnt  out  1  read accepted this cycle (combinational, IDLE only)
- o_rd_valid  out  1  one-cycle pulse: o_rd_data is new
- o_rd_data  out  16  last read word, held until next read completes
- i_wr_req  in  1  write request; held with addr/data/be stable until o_wr_gnt
- i_wr_addr  in  20  write word address
- i_wr_data  in  16  write data
- i_wr_be  in  2  byte enables, [0]=low byte, [1]=high byte
- o_wr_gnt  out  1  write accepted this cycle (combinational, IDLE only)
- o_busy  out  1  FSM not in IDLE
- o_sram_addr  out  20  SRAM address (registered)
- o_sram_dq_out  out  16  write data to pad
- o_sram_dq_oe  out  1  pad output enable
- i_sram_dq  in  16  data from pad
- o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  out  1 each  active-low SRAM controls (registered)

Behaviour:
- Reset values:
  - FSM = IDLE;
  - o_sram_addr=0, o_sram_dq_out=0, o_sram_dq_oe=0;
  - all *_n outputs = 1;
  - o_rd_data=0, o_rd_valid=0, o_busy=0, starvation counter=0.
- Reset mid-operation: the next edge forces IDLE and all reset values. An in-flight read produces no o_rd_valid. An in-flight write has WE_n deasserted at that edge.
- FSM states and transitions:
  - IDLE -> RD | WR_SETUP
  - RD (READ_WAIT cycles) -> IDLE
  - WR_SETUP (1 cycle) -> WR_PULSE
  - WR_PULSE (WRITE_WAIT cycles) -> WR_HOLD
  - WR_HOLD (1 cycle) -> IDLE
- Arbitration happens only in IDLE. With both requests high, the read wins. Gnt is never asserted outside IDLE.
- On a grant edge the block latches addr, data and be, then drives them from the next cycle.
- Read timing (gnt in cycle T):
  - cycles T+1..T+READ_WAIT: ce_n=0, oe_n=0, we_n=1, lb_n=ub_n=0, dq_oe=0;
  - i_sram_dq is sampled at the end of T+READ_WAIT;
  - o_rd_valid=1 and o_rd_data updated in T+READ_WAIT+1, which is also the IDLE cycle where the next grant can occur.
  - Read latency = READ_WAIT+1 cycles from gnt.
- Write timing (gnt in cycle T):
  - WR_SETUP in T+1: ce_n=0, oe_n=1, we_n=1, dq_oe=1, lb_n=~be[0], ub_n=~be[1];
  - WR_PULSE: same pins with we_n=0;
  - WR_HOLD: we_n=1, dq_oe still 1;
  - IDLE at T+WRITE_WAIT+3.
- be=2'b00 is still granted and fully sequenced, but no byte is modified (lb_n=ub_n=1).
- In IDLE:
  - ce_n, oe_n, we_n, lb_n, ub_n = 1;
  - dq_oe=0;
  - o_sram_addr holds its last value.
- Addresses pass through unmodified, with no wrap or range check. 0xFFFFF is legal.
- o_busy = (state != IDLE).
- o_rd_valid is never high in a cycle other than the one after RD completes.

Optional Feature:
- Macro SRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - an 8-bit counter increments on each read grant made while i_wr_req=1;
  - it clears on a write grant, or in any IDLE cycle with i_wr_req=0;
  - when counter==STARVE_MAX and both requests are high, the write is granted instead of the read.
- Undefined: strict read priority, no counter logic; a write may starve indefinitely.

Test Plan:
- Reset, then idle 10 cycles -> all *_n=1, dq_oe=0, o_busy=0, o_rd_valid never high.
- Single read, addr 0x12345, READ_WAIT=1, i_sram_dq=0xBEEF ->
  - o_rd_gnt in T;
  - o_sram_addr=0x12345 with oe_n=0 in T+1;
  - o_rd_valid=1 with o_rd_data=0xBEEF in T+2.
- Single write, addr 0xFFFFF, data 0xA5C3, be=2'b10, WRITE_WAIT=2 ->
  - we_n=0 in exactly T+2..T+3;
  - ub_n=0, lb_n=1, dq_oe=1 over T+1..T+4;
  - IDLE in T+5.
- Simultaneous rd_req and wr_req held continuously (guard undefined) -> only reads granted for 50 grants; o_wr_gnt stays 0.
- Same stimulus with SRAM_ARB_STARVE_GUARD_EN, STARVE_MAX=8 -> exactly 8 read grants, then 1 write grant, repeating.
- Assert i_rst in the first WR_PULSE cycle -> at the next edge we_n=1, dq_oe=0, state IDLE; no o_wr_gnt until the request is resampled after reset is released.
